// File: rtl/ikinematics_axil_slave.sv
// AXI4-Lite register file terminating S00_AXI of the inverse-kinematics IP; B/R valid one cycle after the completing handshake.
// Responses hold until BREADY/RREADY; one outstanding write and one outstanding read. IKIN_AXIL_WSTRB_EN enables byte-lane strobes.
module ikinematics_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                  reg_wr_pulse
);
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [NUM_REGS-1:0][DW-1:0] regs;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DW-1:0]     wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]  aw_idx, ar_idx;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DW-1:0]     wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [DW-1:0]     rd_word;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign reg_q  = regs;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {{(32-IDX_W){1'b0}}, idx} < 32'(NUM_REGS);
  endfunction

`ifdef IKIN_AXIL_WSTRB_EN
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [STRB_W-1:0] strb);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], wr_strb};
`endif

  // Address and data may come from the live channel or from the half-captured side.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = aw_idx;
    wr_data = S_AXI_WDATA;
    wr_strb = S_AXI_WSTRB;
    case (w_state)
      W_IDLE:   wr_en = aw_hs && w_hs;
      W_HAVE_A: begin
        wr_en  = w_hs;
        wr_idx = aw_idx_q;
      end
      W_HAVE_W: begin
        wr_en   = aw_hs;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
      end
      default:  wr_en = 1'b0;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_word = regs[i];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regs         <= '0;
      reg_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse[i] <= wr_en && (wr_idx == IDX_W'(i));
        if (wr_en && (wr_idx == IDX_W'(i))) begin
`ifdef IKIN_AXIL_WSTRB_EN
          regs[i] <= merge_bytes(regs[i], wr_data, wr_strb);
`else
          regs[i] <= wr_data;
`endif
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      aw_idx_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      if (wr_en) begin
        w_state       <= W_RESP;
        S_AXI_AWREADY <= 1'b0;
        S_AXI_WREADY  <= 1'b0;
        S_AXI_BVALID  <= 1'b1;
        S_AXI_BRESP   <= in_range(wr_idx) ? RESP_OKAY : RESP_SLVERR;
      end else begin
        case (w_state)
          W_IDLE: begin
            if (aw_hs) begin
              w_state       <= W_HAVE_A;
              aw_idx_q      <= aw_idx;
              S_AXI_AWREADY <= 1'b0;
              S_AXI_WREADY  <= 1'b1;
            end else if (w_hs) begin
              w_state       <= W_HAVE_W;
              wdata_q       <= S_AXI_WDATA;
              wstrb_q       <= S_AXI_WSTRB;
              S_AXI_AWREADY <= 1'b1;
              S_AXI_WREADY  <= 1'b0;
            end else begin
              S_AXI_AWREADY <= 1'b1;
              S_AXI_WREADY  <= 1'b1;
            end
          end
          W_RESP: begin
            if (S_AXI_BREADY) begin
              w_state       <= W_IDLE;
              S_AXI_BVALID  <= 1'b0;
              S_AXI_AWREADY <= 1'b1;
              S_AXI_WREADY  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state       <= R_DATA;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_word;
            S_AXI_RRESP   <= in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_state       <= R_IDLE;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ikinematics_axil_slave.sv
// Randomized AXI4-Lite master against a transaction-level register model for ikinematics_axil_slave.
`timescale 1ns/1ps
module tb_ikinematics_axil_slave;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int BUDGET = 50;
`ifdef IKIN_AXIL_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0] reg_wr_pulse;

  always #5 clk = ~clk;

  ikinematics_axil_slave #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  // Model: committed register values, the values a pending write will leave, and response expectations.
  logic [DW-1:0] model_regs [NR];
  logic [DW-1:0] pend_regs [NR];
  logic [NR-1:0] exp_pulse = '0;
  logic [1:0] exp_bresp = 2'b00, exp_rresp = 2'b00;
  logic [DW-1:0] exp_rdata = '0;
  logic prev_b = 1'b0;
  logic b_rise;
  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL timeout %s: no handshake, required within %0d cycles", name, BUDGET);
  endtask

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_w, input logic [DW-1:0] d,
                                               input logic [3:0] s);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (!STRB_EN || s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[DW*i +: DW] = model_regs[i];
    return f;
  endfunction

  // Per-cycle comparison of every meaningful DUT output against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ctrl", {awready, wready, bvalid, bresp, arready, rvalid, rresp, reg_wr_pulse}, '0);
      check("rst_rdata", rdata, '0);
      check("rst_reg_q", reg_q, '0);
      prev_b = 1'b0;
    end else begin
      b_rise = bvalid && !prev_b;
      if (b_rise) model_regs = pend_regs;
      check("reg_q", reg_q, model_flat());
      check("pulse", reg_wr_pulse, b_rise ? exp_pulse : '0);
      if (bvalid) begin
        check("bresp", bresp, exp_bresp);
        check("aw_w_ready_in_resp", {awready, wready}, 2'b00);
      end
      if (rvalid) begin
        check("rdata", rdata, exp_rdata);
        check("rresp", rresp, exp_rresp);
        check("arready_in_rdata", arready, 1'b0);
      end
      prev_b = bvalid;
    end
  end

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_stall, output logic [1:0] bresp_seen);
    int idx;
    logic aw_done, w_done;
    int n_aw, n_w, n_b;
    idx = int'(addr[AW-1:2]);
    aw_done = 0; w_done = 0; n_aw = 0; n_w = 0; n_b = 0;
    pend_regs = model_regs;
    exp_pulse = '0;
    if (idx < NR) begin
      pend_regs[idx] = apply_strb(model_regs[idx], data, strb);
      exp_pulse[idx] = 1'b1;
      exp_bresp = 2'b00;
    end else begin
      exp_bresp = 2'b10;
    end
    fork
      begin
        repeat (aw_dly) @(negedge clk);
        awaddr = addr; awvalid = 1'b1;
        while (!awready && n_aw < BUDGET) begin @(negedge clk); n_aw++; end
        if (n_aw >= BUDGET) timeout("awready");
        @(posedge clk); aw_done = 1'b1;
        @(negedge clk); awvalid = 1'b0;
        if (!w_done) check("awready_low_await_w", awready, 1'b0);
      end
      begin
        repeat (w_dly) @(negedge clk);
        wdata = data; wstrb = strb; wvalid = 1'b1;
        while (!wready && n_w < BUDGET) begin @(negedge clk); n_w++; end
        if (n_w >= BUDGET) timeout("wready");
        @(posedge clk); w_done = 1'b1;
        @(negedge clk); wvalid = 1'b0;
        if (!aw_done) check("wready_low_await_aw", wready, 1'b0);
      end
    join
    check("bvalid_next_cycle", bvalid, 1'b1);
    while (!bvalid && n_b < BUDGET) begin @(negedge clk); n_b++; end
    if (n_b >= BUDGET) timeout("bvalid");
    bresp_seen = bresp;
    for (int i = 0; i < b_stall; i++) begin
      check("bvalid_hold", bvalid, 1'b1);
      @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, input int r_stall, output logic [DW-1:0] got);
    int idx, n;
    idx = int'(addr[AW-1:2]);
    n = 0;
    exp_rdata = (idx < NR) ? model_regs[idx] : '0;
    exp_rresp = (idx < NR) ? 2'b00 : 2'b10;
    repeat (ar_dly) @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout("arready");
    @(posedge clk);
    @(negedge clk); arvalid = 1'b0;
    check("rvalid_next_cycle", rvalid, 1'b1);
    got = rdata;
    for (int i = 0; i < r_stall; i++) begin
      check("rvalid_hold", rvalid, 1'b1);
      @(negedge clk);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk); rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got;
    logic [1:0] br;
    logic [AW-1:0] a;
    for (int i = 0; i < NR; i++) begin model_regs[i] = '0; pend_regs[i] = '0; end

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {awready, wready, arready, bvalid, rvalid}, 5'b11100);

    // Basic write/read of each register
    for (int i = 0; i < NR; i++) axi_write(5'(4*i), 32'(i + 1), 4'hF, 0, 0, 0, br);
    for (int i = 0; i < NR; i++) begin
      axi_read(5'(4*i), 0, 0, got);
      check("basic_read", got, 32'(i + 1));
    end

    // W three cycles ahead of AW
    axi_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0, br);
    check("w_first_reg2", reg_q[95:64], 32'hDEADBEEF);

    // Response backpressure
    axi_write(5'h04, 32'hCAFE0004, 4'hF, 0, 0, 5, br);
    axi_read(5'h04, 0, 5, got);
    check("stalled_read", got, 32'hCAFE0004);

    // Out-of-range index
    axi_write(5'h10, 32'h0BADF00D, 4'hF, 0, 1, 0, br);
    check("oor_bresp", br, 2'b10);
    axi_read(5'h10, 0, 0, got);
    check("oor_rdata", got, 32'h0);

    // Byte strobes
    axi_write(5'h00, 32'h11223344, 4'hF, 0, 0, 0, br);
    axi_write(5'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 0, br);
    axi_read(5'h00, 0, 0, got);
    check("wstrb_merge", got, STRB_EN ? 32'h11BB33DD : 32'hAABBCCDD);

    // Read accepted on the same edge as an update sees the old value
    fork
      axi_write(5'h04, 32'h12345678, 4'hF, 0, 0, 0, br);
      axi_read(5'h04, 0, 0, got);
    join
    check("collision_old", got, 32'hCAFE0004);
    axi_read(5'h04, 0, 0, got);
    check("after_b_new", got, 32'h12345678);

    // Reset while holding an address without data
    @(negedge clk);
    awaddr = 5'h00; awvalid = 1'b1;
    @(posedge clk);
    @(negedge clk); awvalid = 1'b0;
    check("have_a_readys", {awready, wready}, 2'b01);
    #1 rst_n = 1'b0;
    #1 check("async_reset_ctrl", {awready, wready, bvalid, arready, rvalid, reg_wr_pulse}, '0);
    check("async_reset_regs", reg_q, '0);
    for (int i = 0; i < NR; i++) begin model_regs[i] = '0; pend_regs[i] = '0; end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("awready_after_rerelease", awready, 1'b1);
    for (int i = 0; i < NR; i++) begin
      axi_read(5'(4*i), 0, 0, got);
      check("read_after_reset", got, 32'h0);
    end

    // Randomized traffic, aligned and unaligned addresses across the full window
    for (int k = 0; k < 150; k++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), br);
      else
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), got);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
